cpu_sequencer: RTL and testbench
================================

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8, meaning the width of the program counter and the instruction-memory address.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port stall, input, 1 bit: when high, holds state, pc and ir for the cycle.
REQ-005 SHALL have port instr_rdata, input, 16 bits: instruction-memory read data, 1-cycle synchronous latency; fields cond[15:12], opcode[11:8], operand[7:0].
REQ-006 SHALL have port flags_in, input, 4 bits: ALU flags {N,Z,C,V}.
REQ-007 SHALL have port flag_wr_en, input, 1 bit: captures flags_in into the flag register.
REQ-008 SHALL have port imem_addr, output, PC_WIDTH bits: equal to pc.
REQ-009 SHALL have port opcode, output, 4 bits: equal to ir[11:8].
REQ-010 SHALL have port operand, output, 8 bits: equal to ir[7:0].
REQ-011 SHALL have port state, output, 2 bits: phase 0 FETCH, 1 DECODE, 2 EXECUTE, 3 WRITEBACK.
REQ-012 SHALL have port condition_code_check, output, 1 bit: registered pass/fail of ir cond against the flag register.
REQ-013 SHALL have port branch_taken, output, 1 bit: one-cycle pulse on a taken branch.

Function
REQ-014 SHALL advance state 0->1->2->3->0 by one step per clock when stall=0, and hold state when stall=1.
REQ-015 SHALL hold pc constant in states 0 and 1, so that instr_rdata is valid during state 1.
REQ-016 SHALL load ir from instr_rdata on the edge leaving state 1 (only when stall=0).
REQ-017 SHALL hold opcode and operand stable from state 2 until the next ir load.
REQ-018 SHALL register condition_code_check on the same edge as the ir load, evaluated from the incoming instr_rdata[15:12] and the current flag register.
REQ-019 SHALL hold condition_code_check until the next ir load.
REQ-020 SHALL evaluate cond as: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 N==V; 1001 N!=V; 1010 !Z&&N==V; 1011 Z||N!=V; 1100 C&&!Z; 1101 !C||Z; 1110 always 1; 1111 always 0.
REQ-021 SHALL load the flag register from flags_in on any edge where flag_wr_en=1, independent of stall and state.
REQ-022 SHALL use the pre-update flag value for condition evaluation when flag_wr_en coincides with the ir load.
REQ-023 SHALL update pc on the edge leaving state 3 (stall=0): opcode 1100 with condition_code_check=1 gives pc <= operand[PC_WIDTH-1:0] (zero-extended if PC_WIDTH>8); otherwise pc <= pc+1 modulo 2^PC_WIDTH.
REQ-024 SHALL wrap pc from all-ones to 0 without any flag.
REQ-025 SHALL assert branch_taken for exactly the cycle after a taken-branch pc load, and drive it 0 otherwise.
REQ-026 SHALL treat opcodes other than 1100 as pass-through: no effect on pc sequencing beyond increment.
REQ-027 SHALL, with stall held high across a phase boundary, neither skip nor repeat any phase, ir load or pc update.

Reset
REQ-028 SHALL, while rst_n=0, asynchronously force: pc=0, state=0, ir=16'hEF00 (cond AL, opcode 1111 NOP, operand 0), flags=0, condition_code_check=0, branch_taken=0.
REQ-029 SHALL restart at state 0, pc 0 on the first clock edge after rst_n deasserts, with no partial instruction retained when reset is asserted mid-sequence.

Verification
REQ-030 SHALL cover: reset release, stall=0, memory returning 16'hE000 at every address -> state 0,1,2,3,0 repeats, pc 0,1,2 increments each 4 cycles, condition_code_check=1 from first ir load.
REQ-031 SHALL cover: flags Z=1 via flag_wr_en, then instruction 16'h0C20 (EQ, branch to 0x20) -> pc=0x20 after state 3, branch_taken 1 for one cycle; same with Z=0 -> pc+1, no pulse.
REQ-032 SHALL cover: pc=0xFF with a non-branch instruction -> pc=0x00 after state 3.
REQ-033 SHALL cover: stall high 3 cycles during state 2 -> state stays 2 for 4 cycles, opcode, pc and condition_code_check unchanged, then normal sequence.
REQ-034 SHALL cover: flag_wr_en with Z 0->1 on the ir-load edge for an EQ instruction -> condition_code_check=0 (old flags used).
REQ-035 SHALL cover: rst_n pulsed low in state 3 -> all outputs at reset values immediately, without waiting for a clock edge; pc stays 0 (no increment).

Source files
------------

// File: rtl/cpu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_sequencer: 4-phase fetch/decode/execute/writeback sequencer with     |
// | conditional branch on registered NZCV flags.          Revision: 1.0      |
// +--------------------------------------------------------------------------+
module cpu_sequencer #(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic [15:0]         instr_rdata,
  input  logic [3:0]          flags_in,
  input  logic                flag_wr_en,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic [3:0]          opcode,
  output logic [7:0]          operand,
  output logic [1:0]          state,
  output logic                condition_code_check,
  output logic                branch_taken
);

  typedef enum logic [1:0] {
    FETCH     = 2'd0,
    DECODE    = 2'd1,
    EXECUTE   = 2'd2,
    WRITEBACK = 2'd3
  } state_t;

  localparam logic [3:0] OP_BRANCH = 4'hC;

  state_t              cur_state, next_state;
  logic                load_ir, update_pc, take_branch;
  logic [PC_WIDTH-1:0] pc, pc_inc, branch_target;
  logic [11:0]         ir;        // cond is consumed at load time, so only opcode/operand are kept
  logic [3:0]          flag_reg;  // {N,Z,C,V}

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    {n, z, cy, v} = f;
    r = 1'b0;
    case (c)
      4'h0: r = z;
      4'h1: r = !z;
      4'h2: r = cy;
      4'h3: r = !cy;
      4'h4: r = n;
      4'h5: r = !n;
      4'h6: r = v;
      4'h7: r = !v;
      4'h8: r = (n == v);
      4'h9: r = (n != v);
      4'hA: r = !z && (n == v);
      4'hB: r = z || (n != v);
      4'hC: r = cy && !z;
      4'hD: r = !cy || z;
      4'hE: r = 1'b1;
      4'hF: r = 1'b0;
    endcase
    return r;
  endfunction

  if (PC_WIDTH > 8) begin : g_target_wide
    assign branch_target = {{(PC_WIDTH-8){1'b0}}, ir[7:0]};
  end else begin : g_target_narrow
    assign branch_target = ir[PC_WIDTH-1:0];
  end

  assign pc_inc      = pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  assign take_branch = (ir[11:8] == OP_BRANCH) && condition_code_check;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur_state <= FETCH;
    else        cur_state <= next_state;
  end

  always_comb begin
    next_state = cur_state;
    load_ir    = 1'b0;
    update_pc  = 1'b0;
    if (!stall) begin
      case (cur_state)
        FETCH:     next_state = DECODE;
        DECODE: begin
          next_state = EXECUTE;
          load_ir    = 1'b1;
        end
        EXECUTE:   next_state = WRITEBACK;
        WRITEBACK: begin
          next_state = FETCH;
          update_pc  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc                   <= '0;
      ir                   <= 12'hF00;
      flag_reg             <= 4'h0;
      condition_code_check <= 1'b0;
      branch_taken         <= 1'b0;
    end else begin
      branch_taken <= 1'b0;
      if (flag_wr_en) flag_reg <= flags_in;
      // Condition uses the flag value before any same-edge flag write.
      if (load_ir) begin
        ir                   <= instr_rdata[11:0];
        condition_code_check <= cond_pass(instr_rdata[15:12], flag_reg);
      end
      if (update_pc) begin
        if (take_branch) begin
          pc           <= branch_target;
          branch_taken <= 1'b1;
        end else begin
          pc <= pc_inc;
        end
      end
    end
  end

  assign imem_addr = pc;
  assign opcode    = ir[11:8];
  assign operand   = ir[7:0];
  assign state     = cur_state;

endmodule
`default_nettype wire

// File: tb/tb_cpu_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpu_sequencer: directed self-checking bench for cpu_sequencer.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_cpu_sequencer;

  logic        clk, rst_n, stall, flag_wr_en;
  logic [15:0] instr_rdata;
  logic [3:0]  flags_in;
  logic [7:0]  imem_addr, operand;
  logic [3:0]  opcode;
  logic [1:0]  state;
  logic        condition_code_check, branch_taken;

  logic [15:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  cpu_sequencer #(.PC_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .instr_rdata(instr_rdata),
    .flags_in(flags_in), .flag_wr_en(flag_wr_en), .imem_addr(imem_addr),
    .opcode(opcode), .operand(operand), .state(state),
    .condition_code_check(condition_code_check), .branch_taken(branch_taken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory, one cycle of read latency.
  always @(posedge clk) instr_rdata <= mem[imem_addr];

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; stall = 1'b0; flag_wr_en = 1'b0; flags_in = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic fill_mem(input logic [15:0] w);
    for (int i = 0; i < 256; i++) mem[i] = w;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_pc got %h want 00", imem_addr); end
    checks++; if (opcode !== 4'hF) begin errors++; $display("FAIL reset_opcode got %h want F", opcode); end
    checks++; if (operand !== 8'h00) begin errors++; $display("FAIL reset_operand got %h want 00", operand); end
    checks++; if (condition_code_check !== 1'b0) begin errors++; $display("FAIL reset_ccc got %b want 0", condition_code_check); end
    checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL reset_bt got %b want 0", branch_taken); end
    rst_n = 1'b1;
  endtask

  task automatic test_sequence();
    for (int k = 0; k < 13; k++) begin
      checks++; if (state !== 2'(k % 4)) begin errors++; $display("FAIL seq_state k=%0d got %0d want %0d", k, state, k % 4); end
      checks++; if (imem_addr !== 8'(k / 4)) begin errors++; $display("FAIL seq_pc k=%0d got %h want %h", k, imem_addr, k / 4); end
      if (k >= 2) begin
        checks++; if (condition_code_check !== 1'b1) begin errors++; $display("FAIL seq_ccc k=%0d got %b want 1", k, condition_code_check); end
      end
      checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL seq_bt k=%0d got %b want 0", k, branch_taken); end
      step();
    end
  endtask

  task automatic test_branch();
    // Z=1: EQ branch taken
    mem[0] = 16'h0C20;
    do_reset();
    flags_in = 4'b0100; flag_wr_en = 1'b1;
    step();
    flag_wr_en = 1'b0;
    step();
    checks++; if (opcode !== 4'hC || operand !== 8'h20) begin errors++; $display("FAIL br_ir got %h/%h want C/20", opcode, operand); end
    checks++; if (condition_code_check !== 1'b1) begin errors++; $display("FAIL br_ccc got %b want 1", condition_code_check); end
    step();
    checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL br_bt_early got %b want 0", branch_taken); end
    step();
    checks++; if (imem_addr !== 8'h20) begin errors++; $display("FAIL br_pc got %h want 20", imem_addr); end
    checks++; if (branch_taken !== 1'b1) begin errors++; $display("FAIL br_bt got %b want 1", branch_taken); end
    step();
    checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL br_bt_pulse got %b want 0", branch_taken); end
    checks++; if (imem_addr !== 8'h20) begin errors++; $display("FAIL br_pc_hold got %h want 20", imem_addr); end
    // Z=0: not taken
    do_reset();
    step(); step();
    checks++; if (condition_code_check !== 1'b0) begin errors++; $display("FAIL nbr_ccc got %b want 0", condition_code_check); end
    step(); step();
    checks++; if (imem_addr !== 8'h01) begin errors++; $display("FAIL nbr_pc got %h want 01", imem_addr); end
    checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL nbr_bt got %b want 0", branch_taken); end
  endtask

  task automatic test_wrap();
    fill_mem(16'hE000);
    mem[0] = 16'hECFF;
    do_reset();
    repeat (4) step();
    checks++; if (imem_addr !== 8'hFF) begin errors++; $display("FAIL wrap_setup got %h want FF", imem_addr); end
    repeat (3) step();
    checks++; if (opcode !== 4'h0) begin errors++; $display("FAIL wrap_opcode got %h want 0", opcode); end
    step();
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL wrap_pc got %h want 00", imem_addr); end
    checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL wrap_bt got %b want 0", branch_taken); end
  endtask

  task automatic test_stall();
    fill_mem(16'hE000);
    do_reset();
    step(); step();
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL stall_pre got %0d want 2", state); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (state !== 2'd2) begin errors++; $display("FAIL stall_state i=%0d got %0d want 2", i, state); end
      checks++; if (opcode !== 4'h0 || imem_addr !== 8'h00 || condition_code_check !== 1'b1) begin
        errors++; $display("FAIL stall_hold i=%0d got op=%h pc=%h ccc=%b want 0/00/1", i, opcode, imem_addr, condition_code_check);
      end
    end
    stall = 1'b0;
    step();
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL stall_resume got %0d want 3", state); end
    stall = 1'b1;
    repeat (2) step();
    checks++; if (imem_addr !== 8'h00 || state !== 2'd3) begin errors++; $display("FAIL stall_wb got pc=%h st=%0d want 00/3", imem_addr, state); end
    stall = 1'b0;
    step();
    checks++; if (imem_addr !== 8'h01 || state !== 2'd0) begin errors++; $display("FAIL stall_after got pc=%h st=%0d want 01/0", imem_addr, state); end
    step();
    checks++; if (imem_addr !== 8'h01 || state !== 2'd1) begin errors++; $display("FAIL stall_noskip got pc=%h st=%0d want 01/1", imem_addr, state); end
  endtask

  task automatic test_flag_race();
    mem[0] = 16'h0C20;
    do_reset();
    step();
    flags_in = 4'b0100; flag_wr_en = 1'b1;
    step();
    flag_wr_en = 1'b0;
    checks++; if (condition_code_check !== 1'b0) begin errors++; $display("FAIL race_ccc got %b want 0", condition_code_check); end
    step(); step();
    checks++; if (imem_addr !== 8'h01 || branch_taken !== 1'b0) begin errors++; $display("FAIL race_pc got pc=%h bt=%b want 01/0", imem_addr, branch_taken); end
  endtask

  task automatic test_async_reset();
    fill_mem(16'hE000);
    do_reset();
    repeat (3) step();
    checks++; if (state !== 2'd3 || condition_code_check !== 1'b1 || opcode !== 4'h0) begin
      errors++; $display("FAIL ares_pre got st=%0d ccc=%b op=%h want 3/1/0", state, condition_code_check, opcode);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || imem_addr !== 8'h00) begin errors++; $display("FAIL ares_state got st=%0d pc=%h want 0/00", state, imem_addr); end
    checks++; if (opcode !== 4'hF || operand !== 8'h00) begin errors++; $display("FAIL ares_ir got %h/%h want F/00", opcode, operand); end
    checks++; if (condition_code_check !== 1'b0 || branch_taken !== 1'b0) begin
      errors++; $display("FAIL ares_flags got ccc=%b bt=%b want 0/0", condition_code_check, branch_taken);
    end
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (imem_addr !== 8'h00 || state !== 2'd0) begin errors++; $display("FAIL ares_release got pc=%h st=%0d want 00/0", imem_addr, state); end
    step();
    checks++; if (imem_addr !== 8'h00 || state !== 2'd1) begin errors++; $display("FAIL ares_restart got pc=%h st=%0d want 00/1", imem_addr, state); end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flag_wr_en = 1'b0; flags_in = 4'h0;
    fill_mem(16'hE000);
    test_reset();
    test_sequence();
    test_branch();
    test_wrap();
    test_stall();
    test_flag_race();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
